hdmi_i2c_config_seq: RTL and testbench
======================================

Name: hdmi_i2c_config_seq

Overview:
- Parametrised successor to the HDMI transmitter I2C configuration block.
- Walks an externally supplied register/value table and writes each entry as a 3-byte I2C write to a parametrised device address.
- Has an integrated single-clock-domain bit engine that uses a tick enable, not a derived clock. Adds NACK retry with limit, done/error status, failing-index report, and re-initialisation on start pulse or hot-plug interrupt.
- Sits between the top-level clk/reset and the HDMI transmitter I2C pads.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- I2C_FREQ, 100000, SCL frequency in Hz. Quarter-period divider QDIV = CLK_FREQ/(4*I2C_FREQ), minimum 1.
- LUT_SIZE, 31, number of table entries, 1..2^IDX_W.
- IDX_W, 8, width of the table index.
- DEV_ADDR, 8'h72, 8-bit write address sent as the first byte. Bit 0 is always sent as 0.
- MAX_RETRY, 3, extra attempts per entry after a NACK before the block reports an error.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; starts or restarts the sequence
- hdmi_tx_int  in  1  active-low interrupt from the transmitter; falling edge requests re-init
- lut_index  out  IDX_W  table index currently addressed
- lut_data  in  16  {reg[15:8], value[7:0]}; valid one clk after lut_index changes
- scl_oe  out  1  1 = drive SCL low; 0 = release
- sda_oe  out  1  1 = drive SDA low; 0 = release
- sda_in  in  1  sampled SDA pad level
- busy  out  1  sequence in progress
- done  out  1  all LUT_SIZE entries acknowledged; held until next start
- error  out  1  retry limit exhausted; held until next start
- err_index  out  IDX_W  index of the failing entry; valid while error=1

Behaviour:
- Reset (asynchronous, active-low) values: scl_oe=0, sda_oe=0, busy=0, done=0, error=0, lut_index=0, err_index=0, retry count 0, state IDLE. Asserting reset mid-transfer releases both lines immediately; no STOP is generated.
- Tick: a counter 0..QDIV-1 produces a one-clk tick. One SCL bit takes 4 ticks: Q0 SCL low and SDA set; Q1 SCL released; Q2 SCL high, sda_in sampled; Q3 SCL driven low. The counter is held at 0 outside XFER.
- Bit engine frame:
  - START: SDA low while SCL is high, then SCL low.
  - Then three bytes, MSB first: DEV_ADDR&8'hFE, lut_data[15:8], lut_data[7:0]. Each byte is followed by an ACK slot with SDA released and sda_in sampled at Q2. A sample of 1 is a NACK.
  - STOP: SDA low, SCL released, then SDA released.
  - After the first NACK the engine skips the remaining bytes and goes straight to STOP.
  - lut_data is latched into a 16-bit shift register at frame start; later changes on lut_data have no effect.
- Sequencer states:
  - IDLE: busy=0. start or re-init request -> FETCH with lut_index=0, retry=0, done=0, error=0.
  - FETCH: one clk for lut_data to settle -> XFER.
  - XFER: runs one frame -> CHECK when STOP completes.
  - CHECK: all ACKs -> NEXT. NACK with retry<MAX_RETRY -> retry+1, then XFER with the same index. NACK with retry==MAX_RETRY -> ERROR with err_index=lut_index.
  - NEXT: if lut_index==LUT_SIZE-1 -> DONE. Otherwise lut_index+1, retry=0, then FETCH.
  - DONE: done=1, busy=0, lut_index holds the last value.
  - ERROR: error=1, busy=0.
- busy=1 in FETCH, XFER, CHECK and NEXT.
- Re-init request: start pulse, or a falling edge on hdmi_tx_int, detected via a 2-flop synchroniser plus an edge register. Honoured only in IDLE, DONE or ERROR. Requests while busy=1 are ignored and are not queued.
- start and a hdmi_tx_int edge in the same cycle count as a single request.
- The index never wraps past LUT_SIZE-1. With LUT_SIZE=1 the block goes straight from NEXT to DONE.

Test Plan:
- QDIV=2, LUT_SIZE=3, bus model ACKs everything. Pulse start -> 3 frames, 29 SCL pulses each, bytes 72/reg/val on the bus. done=1 after the third STOP, busy=0, error=0, lut_index=2.
- Bus model NACKs the address byte of entry 1 twice, then ACKs -> entry 1 is sent 3 times, no further bytes after each NACK, ends with done=1.
- Entry 2 always NACKs the data byte, MAX_RETRY=3 -> 4 attempts, then error=1, err_index=2, done=0, scl_oe=0, sda_oe=0.
- After done=1, drive hdmi_tx_int 1->0 -> sequence restarts at index 0 and done clears. A second falling edge while busy=1 -> ignored, and the sequence completes exactly once.
- Assert reset during the data byte of entry 1 -> same cycle scl_oe=0, sda_oe=0, busy=0. After release and start -> clean sequence from index 0.
- start and a hdmi_tx_int falling edge in the same cycle in IDLE -> exactly one sequence run. SCL high time = 2*QDIV clks, checked for QDIV=1 and QDIV=5.

Source files
------------

// File: rtl/hdmi_i2c_config_seq.sv
// hdmi_i2c_config_seq
//   Walks an external register/value table and writes every entry to the HDMI
//   transmitter as a 3-byte I2C write: {DEV_ADDR & 8'hFE, reg, value}. The bit
//   engine runs in the system clock domain and is paced by a quarter-bit tick.
//   A NACKed entry is retried up to MAX_RETRY extra times before the block
//   stops with error. A start pulse or a hot-plug interrupt falling edge
//   re-runs the table from entry 0.
//
// Ports
//   clk, reset        system clock, asynchronous active-low reset
//   start             one-cycle pulse, starts or restarts the table walk
//   hdmi_tx_int       active-low interrupt, falling edge requests re-init
//   lut_index         table entry currently addressed
//   lut_data          {reg, value} for lut_index, valid one clk after it changes
//   scl_oe / sda_oe   1 pulls the pad low, 0 releases it (open drain)
//   sda_in            sampled SDA pad level
//   busy/done/error   sequence status, done/error held until the next run
//   err_index         entry that exhausted its retries (valid with error)
module hdmi_i2c_config_seq #(
    parameter int         CLK_FREQ  = 50000000,
    parameter int         I2C_FREQ  = 100000,
    parameter int         LUT_SIZE  = 31,
    parameter int         IDX_W     = 8,
    parameter logic [7:0] DEV_ADDR  = 8'h72,
    parameter int         MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             hdmi_tx_int,
    output logic [IDX_W-1:0] lut_index,
    input  logic [15:0]      lut_data,
    output logic             scl_oe,
    output logic             sda_oe,
    input  logic             sda_in,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_index
);

    localparam int QDIV_RAW = CLK_FREQ / (4 * I2C_FREQ);
    localparam int QDIV     = (QDIV_RAW < 1) ? 1 : QDIV_RAW;
    localparam int CNT_W    = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(QDIV - 1);
    localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(LUT_SIZE - 1);
    localparam logic [7:0]       ADDR_BYTE = DEV_ADDR & 8'hFE;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    // Frame slots: START, 27 bit slots (3 bytes x {8 data + ACK}), STOP.
    localparam logic [1:0] PH_START = 2'd0;
    localparam logic [1:0] PH_BIT   = 2'd1;
    localparam logic [1:0] PH_STOP  = 2'd2;

    logic [2:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [1:0]       qtr_q,     qtr_d;
    logic [1:0]       phase_q,   phase_d;
    logic [1:0]       byte_q,    byte_d;
    logic [3:0]       bit_q,     bit_d;      // 0..7 data (MSB first), 8 = ACK slot
    logic             nack_q,    nack_d;
    logic [15:0]      data_q,    data_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic [RTY_W-1:0] retry_q,   retry_d;
    logic             done_q,    done_d;
    logic             error_q,   error_d;
    logic [IDX_W-1:0] err_idx_q, err_idx_d;
    logic             scl_oe_q,  scl_oe_d;
    logic             sda_oe_q,  sda_oe_d;
    logic             int_meta_q, int_sync_q, int_prev_q;

    logic       tick;
    logic       reinit;
    logic [7:0] tx_byte;
    logic       tx_bit;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = '0;
        qtr_d     = qtr_q;
        phase_d   = phase_q;
        byte_d    = byte_q;
        bit_d     = bit_q;
        nack_d    = nack_q;
        data_d    = data_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        done_d    = done_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        scl_oe_d  = 1'b0;
        sda_oe_d  = 1'b0;

        tick   = (state_q == S_XFER) && (cnt_q == CNT_LAST);
        reinit = start | (int_prev_q & ~int_sync_q);

        case (byte_q)
            2'd0:    tx_byte = ADDR_BYTE;
            2'd1:    tx_byte = data_q[15:8];
            default: tx_byte = data_q[7:0];
        endcase
        tx_bit = tx_byte[~bit_q[2:0]];

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (reinit) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    retry_d = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end
            end
            S_FETCH: state_d = S_XFER;
            S_XFER: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                // The table word is re-captured through the whole first quarter
                // of START, so it is stable long before the reg byte is shifted.
                if (phase_q == PH_START && qtr_q == 2'd0)
                    data_d = lut_data;

                // Line decode for the current quarter; registered below so the
                // pads are driven from flops.
                case (phase_q)
                    PH_START: begin
                        scl_oe_d = (qtr_q == 2'd3);
                        sda_oe_d = (qtr_q != 2'd0);
                    end
                    PH_BIT: begin
                        scl_oe_d = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                        sda_oe_d = (bit_q != 4'd8) && !tx_bit;
                    end
                    default: begin
                        scl_oe_d = (qtr_q == 2'd0);
                        sda_oe_d = (qtr_q != 2'd3);
                    end
                endcase

                if (tick) begin
                    if (qtr_q != 2'd3) begin
                        qtr_d = qtr_q + 2'd1;
                        if (phase_q == PH_BIT && bit_q == 4'd8 && qtr_q == 2'd2)
                            nack_d = sda_in;
                    end else begin
                        qtr_d = 2'd0;
                        case (phase_q)
                            PH_START: phase_d = PH_BIT;
                            PH_BIT: begin
                                if (bit_q != 4'd8) begin
                                    bit_d = bit_q + 4'd1;
                                end else if (nack_q || byte_q == 2'd2) begin
                                    phase_d = PH_STOP;
                                end else begin
                                    byte_d = byte_q + 2'd1;
                                    bit_d  = 4'd0;
                                end
                            end
                            default: state_d = S_CHECK;
                        endcase
                    end
                end
            end
            S_CHECK: begin
                if (!nack_q) begin
                    state_d = S_NEXT;
                end else if (retry_q < RTY_MAX) begin
                    retry_d = retry_q + 1'b1;
                    state_d = S_XFER;
                end else begin
                    state_d   = S_ERROR;
                    error_d   = 1'b1;
                    err_idx_d = idx_q;
                end
            end
            S_NEXT: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    retry_d = '0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every entry into XFER begins a fresh frame.
        if (state_d == S_XFER && state_q != S_XFER) begin
            phase_d = PH_START;
            qtr_d   = 2'd0;
            byte_d  = 2'd0;
            bit_d   = 4'd0;
            nack_d  = 1'b0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            qtr_q      <= 2'd0;
            phase_q    <= PH_START;
            byte_q     <= 2'd0;
            bit_q      <= 4'd0;
            nack_q     <= 1'b0;
            data_q     <= 16'h0000;
            idx_q      <= '0;
            retry_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_idx_q  <= '0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            // Interrupt line idles high; resetting the synchroniser to 1
            // prevents a false falling edge right after reset.
            int_meta_q <= 1'b1;
            int_sync_q <= 1'b1;
            int_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            qtr_q      <= qtr_d;
            phase_q    <= phase_d;
            byte_q     <= byte_d;
            bit_q      <= bit_d;
            nack_q     <= nack_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_idx_q  <= err_idx_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
            int_meta_q <= hdmi_tx_int;
            int_sync_q <= int_meta_q;
            int_prev_q <= int_sync_q;
        end
    end

    assign lut_index = idx_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;
    assign busy      = (state_q == S_FETCH) || (state_q == S_XFER) ||
                       (state_q == S_CHECK) || (state_q == S_NEXT);
    assign done      = done_q;
    assign error     = error_q;
    assign err_index = err_idx_q;

endmodule

// File: tb/tb_hdmi_i2c_config_seq.sv
// Directed bench for hdmi_i2c_config_seq: a main instance (QDIV=2, 3 entries)
// driven by an I2C slave model that decodes frames and can NACK selectively,
// plus two single-entry instances (QDIV=1 and QDIV=5) used for SCL timing.
module tb_hdmi_i2c_config_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start, hdmi_tx_int, aux_start;

    // main instance
    logic [7:0]  m_lut_index, m_err_index;
    logic [15:0] m_lut_data;
    logic        m_scl_oe, m_sda_oe, m_sda_in, m_busy, m_done, m_error;
    logic        slv_oe;

    hdmi_i2c_config_seq #(
        .CLK_FREQ(800000), .I2C_FREQ(100000), .LUT_SIZE(3), .IDX_W(8),
        .DEV_ADDR(8'h72), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .reset(rst_n), .start(start), .hdmi_tx_int(hdmi_tx_int),
        .lut_index(m_lut_index), .lut_data(m_lut_data),
        .scl_oe(m_scl_oe), .sda_oe(m_sda_oe), .sda_in(m_sda_in),
        .busy(m_busy), .done(m_done), .error(m_error), .err_index(m_err_index)
    );

    assign m_sda_in = ~(m_sda_oe | slv_oe);

    function automatic logic [15:0] tbl(input logic [7:0] idx);
        case (idx)
            8'd0:    tbl = 16'h15A1;
            8'd1:    tbl = 16'h163C;
            8'd2:    tbl = 16'h4110;
            default: tbl = 16'hFFFF;
        endcase
    endfunction

    // Synchronous table: data follows the index one clock later.
    always @(posedge clk) m_lut_data <= tbl(m_lut_index);

    // aux instances (single entry, ACK everything)
    logic [7:0] q1_idx, q1_eidx, q5_idx, q5_eidx;
    logic       q1_scl_oe, q1_sda_oe, q1_sda_in, q1_busy, q1_done, q1_error;
    logic       q5_scl_oe, q5_sda_oe, q5_sda_in, q5_busy, q5_done, q5_error;
    logic       aux_ack [2];

    hdmi_i2c_config_seq #(
        .CLK_FREQ(400000), .I2C_FREQ(100000), .LUT_SIZE(1), .IDX_W(8),
        .DEV_ADDR(8'h72), .MAX_RETRY(3)
    ) dut_q1 (
        .clk(clk), .reset(rst_n), .start(aux_start), .hdmi_tx_int(1'b1),
        .lut_index(q1_idx), .lut_data(16'h1234),
        .scl_oe(q1_scl_oe), .sda_oe(q1_sda_oe), .sda_in(q1_sda_in),
        .busy(q1_busy), .done(q1_done), .error(q1_error), .err_index(q1_eidx)
    );

    hdmi_i2c_config_seq #(
        .CLK_FREQ(2000000), .I2C_FREQ(100000), .LUT_SIZE(1), .IDX_W(8),
        .DEV_ADDR(8'h72), .MAX_RETRY(3)
    ) dut_q5 (
        .clk(clk), .reset(rst_n), .start(aux_start), .hdmi_tx_int(1'b1),
        .lut_index(q5_idx), .lut_data(16'h1234),
        .scl_oe(q5_scl_oe), .sda_oe(q5_sda_oe), .sda_in(q5_sda_in),
        .busy(q5_busy), .done(q5_done), .error(q5_error), .err_index(q5_eidx)
    );

    assign q1_sda_in = ~(q1_sda_oe | aux_ack[0]);
    assign q5_sda_in = ~(q5_sda_oe | aux_ack[1]);

    // ------------------------------------------------------------------
    // Main slave model: decodes START/bytes/STOP from the line levels and
    // logs every completed frame. mode 0: ACK all; mode 1: NACK the address
    // of entry 1 on its first two attempts; mode 2: always NACK the data
    // byte of entry 2.
    // ------------------------------------------------------------------
    int         mode = 0;
    int         nf, nb, rcnt, cur_idx, cur_att;
    int         att [4];
    logic       pscl, psda, in_frame;
    logic [7:0] sh;
    logic [7:0] fb [3];
    int         f_idx [16], f_nb [16], f_rise [16];
    logic [7:0] f_b0 [16], f_b1 [16], f_b2 [16];

    function automatic logic nack_now(input int m, input int idx, input int a, input int byt);
        nack_now = (m == 1 && idx == 1 && a < 2 && byt == 0) ||
                   (m == 2 && idx == 2 && byt == 2);
    endfunction

    always @(negedge clk) begin : slave
        logic scl_l, sda_l;
        scl_l = ~m_scl_oe;
        sda_l = ~(m_sda_oe | slv_oe);
        if (!rst_n) begin
            slv_oe = 1'b0; in_frame = 1'b0; nf = 0; nb = 0; rcnt = 0;
            pscl = 1'b1; psda = 1'b1;
            for (int i = 0; i < 4; i++) att[i] = 0;
        end else begin
            if (pscl && scl_l && psda && !sda_l) begin
                in_frame = 1'b1; rcnt = 0; nb = 0; sh = 8'h00;
                cur_idx = int'(m_lut_index) & 3;
                cur_att = att[cur_idx];
                att[cur_idx]++;
                for (int i = 0; i < 3; i++) fb[i] = 8'h00;
            end else if (in_frame && pscl && scl_l && !psda && sda_l) begin
                if (nf < 16) begin
                    f_idx[nf] = cur_idx; f_nb[nf] = nb; f_rise[nf] = rcnt;
                    f_b0[nf] = fb[0]; f_b1[nf] = fb[1]; f_b2[nf] = fb[2];
                end
                nf++;
                in_frame = 1'b0;
            end else if (in_frame && !pscl && scl_l) begin
                rcnt++;
                if (rcnt % 9 != 0) sh = {sh[6:0], sda_l};
            end else if (in_frame && pscl && !scl_l) begin
                if (rcnt % 9 == 8) begin
                    if (nb < 3) fb[nb] = sh;
                    slv_oe = ~nack_now(mode, cur_idx, cur_att, nb);
                    nb++;
                end else begin
                    slv_oe = 1'b0;
                end
            end
            pscl = scl_l;
            psda = sda_l;
        end
    end

    // Aux slave: ACKs every byte, counts SCL rising edges and measures the
    // high time (in clocks) of every SCL pulse that has both edges.
    logic a_pscl [2], a_psda [2], a_rose [2];
    int   a_rcnt [2], a_run [2], a_hmin [2], a_hmax [2];

    always @(negedge clk) begin : aux_slave
        logic scl_a [2];
        logic sda_a [2];
        scl_a[0] = ~q1_scl_oe; sda_a[0] = ~(q1_sda_oe | aux_ack[0]);
        scl_a[1] = ~q5_scl_oe; sda_a[1] = ~(q5_sda_oe | aux_ack[1]);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                aux_ack[i] = 1'b0; a_pscl[i] = 1'b1; a_psda[i] = 1'b1; a_rose[i] = 1'b0;
                a_rcnt[i] = 0; a_run[i] = 0; a_hmin[i] = 1000; a_hmax[i] = 0;
            end else begin
                if (a_pscl[i] && scl_a[i] && a_psda[i] && !sda_a[i]) a_rcnt[i] = 0;
                if (scl_a[i]) begin
                    if (!a_pscl[i]) begin
                        a_rcnt[i]++; a_rose[i] = 1'b1; a_run[i] = 1;
                    end else begin
                        a_run[i]++;
                    end
                end else if (a_pscl[i]) begin
                    if (a_rose[i]) begin
                        if (a_run[i] < a_hmin[i]) a_hmin[i] = a_run[i];
                        if (a_run[i] > a_hmax[i]) a_hmax[i] = a_run[i];
                    end
                    a_rose[i]  = 1'b0;
                    aux_ack[i] = (a_rcnt[i] % 9 == 8);
                end
                a_pscl[i] = scl_a[i];
                a_psda[i] = sda_a[i];
            end
        end
    end

    // ------------------------------------------------------------------
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_main(input int budget, input string tag);
        int c;
        c = 0;
        while (!(m_done || m_error) && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        check({tag, "_timeout"}, 32'(c < budget), 32'd1);
    endtask

    initial begin
        int c;
        int e_idx2 [5] = '{0, 1, 1, 1, 2};
        int e_nb2  [5] = '{3, 1, 1, 3, 3};
        int e_rs2  [5] = '{28, 10, 10, 28, 28};
        int e_idx3 [6] = '{0, 1, 2, 2, 2, 2};
        logic [15:0] w;

        rst_n = 1'b0; start = 1'b0; hdmi_tx_int = 1'b1; aux_start = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_scl_oe", 32'(m_scl_oe), 32'd0);
        check("rst_sda_oe", 32'(m_sda_oe), 32'd0);
        check("rst_busy", 32'(m_busy), 32'd0);
        check("rst_done", 32'(m_done), 32'd0);
        check("rst_error", 32'(m_error), 32'd0);
        check("rst_lut_index", 32'(m_lut_index), 32'd0);
        check("rst_err_index", 32'(m_err_index), 32'd0);
        #1 rst_n = 1'b1;

        // 1: clean run, all ACKed
        mode = 0;
        pulse_start();
        #1 check("t1_busy_run", 32'(m_busy), 32'd1);
        wait_main(4000, "t1");
        check("t1_done", 32'(m_done), 32'd1);
        check("t1_error", 32'(m_error), 32'd0);
        check("t1_busy", 32'(m_busy), 32'd0);
        check("t1_lut_index", 32'(m_lut_index), 32'd2);
        check("t1_frames", 32'(nf), 32'd3);
        for (int i = 0; i < 3; i++) begin
            w = tbl(8'(i));
            check($sformatf("t1_f%0d_idx", i), 32'(f_idx[i]), 32'(i));
            check($sformatf("t1_f%0d_nb", i), 32'(f_nb[i]), 32'd3);
            check($sformatf("t1_f%0d_addr", i), 32'(f_b0[i]), 32'h72);
            check($sformatf("t1_f%0d_reg", i), 32'(f_b1[i]), 32'(w[15:8]));
            check($sformatf("t1_f%0d_val", i), 32'(f_b2[i]), 32'(w[7:0]));
            // 28 rising edges plus the high phase before START = 29 pulses
            check($sformatf("t1_f%0d_rise", i), 32'(f_rise[i]), 32'd28);
        end

        // 2: entry 1 address NACKed twice, then ACKed
        do_reset();
        mode = 1;
        pulse_start();
        wait_main(6000, "t2");
        check("t2_done", 32'(m_done), 32'd1);
        check("t2_error", 32'(m_error), 32'd0);
        check("t2_frames", 32'(nf), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_f%0d_idx", i), 32'(f_idx[i]), 32'(e_idx2[i]));
            check($sformatf("t2_f%0d_nb", i), 32'(f_nb[i]), 32'(e_nb2[i]));
            check($sformatf("t2_f%0d_rise", i), 32'(f_rise[i]), 32'(e_rs2[i]));
        end

        // 3: entry 2 data byte always NACKed -> 4 attempts, error
        do_reset();
        mode = 2;
        pulse_start();
        wait_main(6000, "t3");
        check("t3_error", 32'(m_error), 32'd1);
        check("t3_done", 32'(m_done), 32'd0);
        check("t3_busy", 32'(m_busy), 32'd0);
        check("t3_err_index", 32'(m_err_index), 32'd2);
        check("t3_scl_oe", 32'(m_scl_oe), 32'd0);
        check("t3_sda_oe", 32'(m_sda_oe), 32'd0);
        check("t3_frames", 32'(nf), 32'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t3_f%0d_idx", i), 32'(f_idx[i]), 32'(e_idx3[i]));
        check("t3_last_val", 32'(f_b2[5]), 32'h10);

        // 4: hot-plug re-init after done; second edge while busy ignored
        do_reset();
        mode = 0;
        pulse_start();
        wait_main(4000, "t4a");
        check("t4_first_done", 32'(m_done), 32'd1);
        #1 hdmi_tx_int = 1'b0;
        c = 0;
        while (!m_busy && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        check("t4_restart_busy", 32'(m_busy), 32'd1);
        check("t4_done_cleared", 32'(m_done), 32'd0);
        check("t4_index0", 32'(m_lut_index), 32'd0);
        repeat (100) @(posedge clk);
        #1 hdmi_tx_int = 1'b1;
        repeat (10) @(posedge clk);
        #1 hdmi_tx_int = 1'b0;
        repeat (10) @(posedge clk);
        #1 hdmi_tx_int = 1'b1;
        wait_main(4000, "t4b");
        check("t4_frames", 32'(nf), 32'd6);
        repeat (300) @(posedge clk);
        #1;
        check("t4_no_requeue_busy", 32'(m_busy), 32'd0);
        check("t4_no_requeue_frames", 32'(nf), 32'd6);
        check("t4_final_done", 32'(m_done), 32'd1);

        // 5: reset during the data byte of entry 1
        do_reset();
        mode = 0;
        pulse_start();
        c = 0;
        while (!(m_lut_index == 8'd1 && nb == 2 && in_frame && m_scl_oe) && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        check("t5_reach_timeout", 32'(c < 3000), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_scl_oe", 32'(m_scl_oe), 32'd0);
        check("t5_rst_sda_oe", 32'(m_sda_oe), 32'd0);
        check("t5_rst_busy", 32'(m_busy), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        pulse_start();
        wait_main(4000, "t5");
        check("t5_done", 32'(m_done), 32'd1);
        check("t5_frames", 32'(nf), 32'd3);
        check("t5_f0_idx", 32'(f_idx[0]), 32'd0);
        check("t5_f0_reg", 32'(f_b1[0]), 32'h15);

        // 6: start and interrupt falling edge together -> one run
        do_reset();
        mode = 0;
        @(posedge clk); #1;
        start = 1'b1; hdmi_tx_int = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        wait_main(4000, "t6");
        repeat (400) @(posedge clk);
        #1;
        check("t6_frames", 32'(nf), 32'd3);
        check("t6_busy", 32'(m_busy), 32'd0);
        check("t6_done", 32'(m_done), 32'd1);
        hdmi_tx_int = 1'b1;

        // 7: SCL high time = 2*QDIV for QDIV=1 and QDIV=5, LUT_SIZE=1
        do_reset();
        @(posedge clk); #1 aux_start = 1'b1;
        @(posedge clk); #1 aux_start = 1'b0;
        c = 0;
        while (!(q1_done && q5_done) && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        check("t7_timeout", 32'(c < 3000), 32'd1);
        check("q1_done", 32'(q1_done), 32'd1);
        check("q1_index", 32'(q1_idx), 32'd0);
        check("q1_rise", 32'(a_rcnt[0]), 32'd28);
        check("q1_hmin", 32'(a_hmin[0]), 32'd2);
        check("q1_hmax", 32'(a_hmax[0]), 32'd2);
        check("q5_done", 32'(q5_done), 32'd1);
        check("q5_error", 32'(q5_error), 32'd0);
        check("q5_rise", 32'(a_rcnt[1]), 32'd28);
        check("q5_hmin", 32'(a_hmin[1]), 32'd10);
        check("q5_hmax", 32'(a_hmax[1]), 32'd10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
